amm_rr_arbiter: RTL and testbench
=================================

Name: amm_rr_arbiter

Overview:
- Two-port round-robin Avalon-MM arbiter in front of the single slave port of sram_controller.
- Lets two independent masters share one SRAM, for example a test generator and a second traffic generator.
- Forwards one command per cycle and tracks outstanding pipelined reads, so each readdata beat returns to the master that issued the read.

Parameters:
- ADDR_W, 20, address width on all ports.
- DATA_W, 16, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byteenable width.
- MAX_PENDING, 4, maximum outstanding reads; must be a power of two and ≥2.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous reset, active-high
- s_address_i[0:1]  in  2×ADDR_W  per-master address
- s_read_i[0:1]  in  2×1  per-master read request
- s_write_i[0:1]  in  2×1  per-master write request
- s_writedata_i[0:1]  in  2×DATA_W  per-master write data
- s_byteenable_i[0:1]  in  2×BE_W  per-master byte enables
- s_waitrequest_o[0:1]  out  2×1  per-master stall
- s_readdata_o[0:1]  out  2×DATA_W  per-master read data
- s_readdatavalid_o[0:1]  out  2×1  per-master read data valid
- m_address_o  out  ADDR_W  to controller
- m_read_o  out  1  to controller
- m_write_o  out  1  to controller
- m_writedata_o  out  DATA_W  to controller
- m_byteenable_o  out  BE_W  to controller
- m_waitrequest_i  in  1  from controller
- m_readdata_i  in  DATA_W  from controller
- m_readdatavalid_i  in  1  from controller
- err_o  out  1  sticky: readdatavalid received with no pending read

Behaviour:
- Reset values:
  - m_read_o=0, m_write_o=0; m_address/writedata/byteenable = 0.
  - s_waitrequest_o = 2'b11; s_readdatavalid_o = 0; s_readdata_o = 0.
  - err_o=0; pending count 0.
  - last_grant=1, so port 0 has priority first.
- Request definition: req[i] = s_read_i[i] | s_write_i[i]. A port whose read would overflow the pending FIFO (count==MAX_PENDING) is masked out of arbitration. Writes are never masked.
- Arbitration is combinational within the cycle; zero added latency on the command path.
  - If lock=1, grant = locked port.
  - Otherwise, if exactly one eligible request, grant it.
  - If both are eligible, grant the port != last_grant.
- Forwarding:
  - m_* = granted port's signals. m_read_o/m_write_o are 0 when there is no grant.
  - s_waitrequest_o[g] = m_waitrequest_i; the non-granted port sees waitrequest=1.
  - An idle or masked port also sees waitrequest=1.
- Acceptance: accept = (m_read_o|m_write_o) & ~m_waitrequest_i.
  - On accept: last_grant <= g, lock <= 0.
  - If a command is forwarded and m_waitrequest_i=1: lock <= 1 on g. The grant is held until accept, as Avalon requires a stalled master to hold its command.
- Simultaneous read and write from one master is illegal. Treat it as a read, and the command is not dropped.
- Pending-read FIFO: depth MAX_PENDING, 1-bit port ID per entry, registered pointers plus a count of width $clog2(MAX_PENDING)+1.
  - Push g on accepted read.
  - Pop on m_readdatavalid_i.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full masking uses the registered count only, so no read is accepted when count==MAX_PENDING, even if a pop happens that cycle.
- Read return: s_readdatavalid_o[head_id] = m_readdatavalid_i, combinational, same cycle. s_readdata_o[both] = m_readdata_i.
- Error: m_readdatavalid_i with count==0 sets err_o. The beat is dropped and no s_readdatavalid_o is asserted. err_o clears only on reset.
- Reset mid-operation clears lock, FIFO and err_o immediately. In-flight data after reset is an error case and flags err_o.

Decomposition:
- tb/rtl shared package amm_arb_pkg holds:
  - typedef port_id_t (logic[0:0]);
  - localparam NUM_PORTS=2;
  - function rr_pick(req, last) returning port_id_t.
- One sub-module, amm_id_fifo: a parametrised sync FIFO of port IDs with push, pop, head, count, full and empty.
- The arbiter instantiates amm_id_fifo plus grant/lock logic, roughly 200 lines total.

Test Plan:
- Single master: port 0 writes 0xBEEF to 0x00010 with m_waitrequest_i=0 → m_write_o=1 for 1 cycle with address 0x00010; s_waitrequest_o[0]=0; port 1 sees waitrequest=1.
- Contention: both ports issue reads each cycle, controller never stalls → grants alternate 0,1,0,1 starting with port 0 after reset. FIFO IDs are 0,1,0,1 and readdatavalid beats route to the matching port.
- Stall lock: port 1 write stalled 3 cycles by m_waitrequest_i=1 while port 0 requests → grant stays on port 1 for all 4 cycles; port 0 is granted the cycle after accept.
- Pending full, MAX_PENDING=4: port 0 issues 5 reads, no data returned → 4 accepted; 5th sees waitrequest=1 and port 1 writes still pass. One readdatavalid frees a slot, and the 5th read is accepted the next cycle.
- Spurious data: m_readdatavalid_i=1 with count=0 → err_o=1 from the next cycle onward, no s_readdatavalid_o pulse.
- Reset with 3 reads pending → after rst_i, count=0, lock=0, err_o=0, last_grant=1.

Source files
------------

// File: rtl/amm_rr_arbiter_pkg.sv
// amm_arb_pkg: shared port-id type, port count and round-robin pick for the two-port Avalon-MM arbiter
package amm_arb_pkg;
  localparam int NUM_PORTS = 2;
  typedef logic [0:0] port_id_t;
  function automatic port_id_t rr_pick(input logic [NUM_PORTS-1:0] req, input port_id_t last);
    return (&req) ? ~last : (req[0] ? 1'b0 : 1'b1);
  endfunction
endpackage

// File: rtl/amm_rr_arbiter_id_fifo.sv
// amm_id_fifo: sync FIFO of port ids (push/push_id in, pop in, head/count/full/empty out)
module amm_id_fifo
  import amm_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  port_id_t push_id_i,
  input  logic     pop_i,
  output port_id_t head_o,
  output logic [AW:0] count_o,
  output logic     full_o,
  output logic     empty_o
);
  port_id_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  always_comb begin
    full_o = r_count == (AW+1)'(DEPTH);
    empty_o = r_count == '0;
    w_push = push_i & ~full_o;
    w_pop = pop_i & ~empty_o;
    head_o = r_mem[r_rd];
    count_o = r_count;
  end
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr] <= push_id_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/amm_rr_arbiter.sv
// amm_rr_arbiter: two-master round-robin Avalon-MM arbiter (s_* slave ports, m_* master port, sticky err_o)
module amm_rr_arbiter
  import amm_arb_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int BE_W = DATA_W / 8,
  parameter int MAX_PENDING = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    s_address_i [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] s_read_i,
  input  logic [NUM_PORTS-1:0] s_write_i,
  input  logic [DATA_W-1:0]    s_writedata_i [NUM_PORTS],
  input  logic [BE_W-1:0]      s_byteenable_i [NUM_PORTS],
  output logic [NUM_PORTS-1:0] s_waitrequest_o,
  output logic [DATA_W-1:0]    s_readdata_o [NUM_PORTS],
  output logic [NUM_PORTS-1:0] s_readdatavalid_o,
  output logic [ADDR_W-1:0]    m_address_o,
  output logic                 m_read_o,
  output logic                 m_write_o,
  output logic [DATA_W-1:0]    m_writedata_o,
  output logic [BE_W-1:0]      m_byteenable_o,
  input  logic                 m_waitrequest_i,
  input  logic [DATA_W-1:0]    m_readdata_i,
  input  logic                 m_readdatavalid_i,
  output logic                 err_o
);
  localparam int CW = $clog2(MAX_PENDING) + 1;
  logic [NUM_PORTS-1:0] w_req, w_elig;
  port_id_t w_gnt, w_head, r_last_grant, r_lock_id;
  logic w_valid, w_cmd, w_accept, w_full, w_empty, r_lock, r_err;
  logic [CW-1:0] w_count;
  amm_id_fifo #(.DEPTH(MAX_PENDING)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(w_accept & m_read_o),
    .push_id_i(w_gnt),
    .pop_i(m_readdatavalid_i),
    .head_o(w_head),
    .count_o(w_count),
    .full_o(w_full),
    .empty_o(w_empty)
  );
  always_comb begin
    w_req = s_read_i | s_write_i;
    w_elig = w_req & ~(s_read_i & {NUM_PORTS{w_full}});
    w_gnt = r_lock ? r_lock_id : rr_pick(w_elig, r_last_grant);
    w_valid = ~rst_i & (r_lock | (|w_elig));
    m_read_o = w_valid & s_read_i[w_gnt];
    m_write_o = w_valid & s_write_i[w_gnt] & ~s_read_i[w_gnt];
    m_address_o = w_valid ? s_address_i[w_gnt] : '0;
    m_writedata_o = w_valid ? s_writedata_i[w_gnt] : '0;
    m_byteenable_o = w_valid ? s_byteenable_i[w_gnt] : '0;
    w_cmd = m_read_o | m_write_o;
    w_accept = w_cmd & ~m_waitrequest_i;
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_waitrequest_o[i] = (w_cmd && w_gnt == port_id_t'(i)) ? m_waitrequest_i : 1'b1;
      s_readdatavalid_o[i] = m_readdatavalid_i & ~w_empty & (w_head == port_id_t'(i));
      s_readdata_o[i] = rst_i ? '0 : m_readdata_i;
    end
    err_o = r_err;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_lock <= 1'b0;
      r_lock_id <= '0;
      r_last_grant <= 1'b1;
      r_err <= 1'b0;
    end else begin
      r_lock <= w_cmd & m_waitrequest_i;
      if (w_cmd) r_lock_id <= w_gnt;
      if (w_accept) r_last_grant <= w_gnt;
      if (m_readdatavalid_i & w_empty) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_amm_rr_arbiter.sv
// tb_amm_rr_arbiter: directed self-checking bench for amm_rr_arbiter
module tb_amm_rr_arbiter;
  logic clk, rst;
  logic [19:0] s_addr [2];
  logic [1:0] s_rd, s_wr, s_wait, s_rdv;
  logic [15:0] s_wd [2];
  logic [1:0] s_be [2];
  logic [15:0] s_rdata [2];
  logic [19:0] m_addr;
  logic m_rd, m_wr, m_wait, m_rdv, err;
  logic [15:0] m_wd, m_rdata;
  logic [1:0] m_be;
  int checks, errors;
  amm_rr_arbiter dut (
    .clk_i(clk),
    .rst_i(rst),
    .s_address_i(s_addr),
    .s_read_i(s_rd),
    .s_write_i(s_wr),
    .s_writedata_i(s_wd),
    .s_byteenable_i(s_be),
    .s_waitrequest_o(s_wait),
    .s_readdata_o(s_rdata),
    .s_readdatavalid_o(s_rdv),
    .m_address_o(m_addr),
    .m_read_o(m_rd),
    .m_write_o(m_wr),
    .m_writedata_o(m_wd),
    .m_byteenable_o(m_be),
    .m_waitrequest_i(m_wait),
    .m_readdata_i(m_rdata),
    .m_readdatavalid_i(m_rdv),
    .err_o(err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1;
    s_rd = 0;
    s_wr = 0;
    m_wait = 0;
    m_rdv = 0;
    m_rdata = 16'h0;
    s_addr[0] = 20'h00010;
    s_addr[1] = 20'h00222;
    s_wd[0] = 16'hBEEF;
    s_wd[1] = 16'h1234;
    s_be[0] = 2'b11;
    s_be[1] = 2'b01;
    #2;
    chk("rst_m_rd", m_rd, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_wait", s_wait, 2'b11);
    chk("rst_rdv", s_rdv, 0);
    chk("rst_err", err, 0);
    tick();
    rst = 0;
    s_wr[0] = 1;
    #1;
    chk("w_m_wr", m_wr, 1);
    chk("w_m_addr", m_addr, 20'h00010);
    chk("w_m_wd", m_wd, 16'hBEEF);
    chk("w_wait", s_wait, 2'b10);
    tick();
    s_wr[0] = 0;
    #1;
    chk("w_m_wr_off", m_wr, 0);
    rst = 1;
    tick();
    rst = 0;
    s_rd = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ct_wait", s_wait, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("ct_m_rd", m_rd, 1);
      tick();
    end
    s_rd = 0;
    #1;
    chk("ct_count", dut.w_count, 4);
    for (int k = 0; k < 4; k++) begin
      m_rdv = 1;
      m_rdata = 16'h1000 + 16'(k);
      #1;
      chk("ct_rdv", s_rdv, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("ct_rdata", s_rdata[k % 2], 16'h1000 + k);
      tick();
    end
    m_rdv = 0;
    #1;
    chk("ct_count0", dut.w_count, 0);
    chk("ct_err", err, 0);
    s_wr[1] = 1;
    m_wait = 1;
    #1;
    chk("lk_m_wr0", m_wr, 1);
    chk("lk_wait0", s_wait, 2'b11);
    tick();
    s_rd[0] = 1;
    for (int k = 1; k < 3; k++) begin
      #1;
      chk("lk_m_wr", m_wr, 1);
      chk("lk_m_rd", m_rd, 0);
      chk("lk_addr", m_addr, 20'h00222);
      tick();
    end
    m_wait = 0;
    #1;
    chk("lk_acc_wait", s_wait, 2'b01);
    chk("lk_acc_wr", m_wr, 1);
    tick();
    s_wr[1] = 0;
    #1;
    chk("lk_p0_rd", m_rd, 1);
    chk("lk_p0_wait", s_wait, 2'b10);
    chk("lk_p0_addr", m_addr, 20'h00010);
    tick();
    s_rd[0] = 0;
    m_rdv = 1;
    #1;
    chk("lk_rdv", s_rdv, 2'b01);
    tick();
    m_rdv = 0;
    s_rd[0] = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("pf_wait", s_wait[0], 0);
      tick();
    end
    #1;
    chk("pf_full_wait", s_wait, 2'b11);
    chk("pf_full_rd", m_rd, 0);
    s_wr[1] = 1;
    #1;
    chk("pf_wr_pass", m_wr, 1);
    chk("pf_wr_wait", s_wait, 2'b01);
    tick();
    s_wr[1] = 0;
    m_rdv = 1;
    #1;
    chk("pf_pop_rdv", s_rdv, 2'b01);
    chk("pf_pop_wait", s_wait[0], 1);
    tick();
    m_rdv = 0;
    #1;
    chk("pf_5th_wait", s_wait[0], 0);
    chk("pf_5th_rd", m_rd, 1);
    tick();
    s_rd = 0;
    #1;
    chk("pf_count", dut.w_count, 4);
    m_rdv = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("pf_drain", s_rdv, 2'b01);
      tick();
    end
    m_rdv = 0;
    #1;
    chk("pf_err", err, 0);
    m_rdv = 1;
    #1;
    chk("sp_rdv", s_rdv, 0);
    chk("sp_err_now", err, 0);
    tick();
    m_rdv = 0;
    #1;
    chk("sp_err", err, 1);
    tick();
    chk("sp_err_hold", err, 1);
    s_rd[1] = 1;
    for (int k = 0; k < 3; k++) tick();
    s_rd[1] = 0;
    s_wr[0] = 1;
    m_wait = 1;
    tick();
    chk("rs_pre_cnt", dut.w_count, 3);
    chk("rs_pre_lock", dut.r_lock, 1);
    rst = 1;
    #1;
    chk("rs_cnt", dut.w_count, 0);
    chk("rs_lock", dut.r_lock, 0);
    chk("rs_err", err, 0);
    chk("rs_last", dut.r_last_grant, 1);
    chk("rs_m_wr", m_wr, 0);
    tick();
    rst = 0;
    s_wr = 0;
    m_wait = 0;
    s_rd = 2'b11;
    #1;
    chk("rs_first_gnt", s_wait, 2'b10);
    tick();
    s_rd = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
